// File: rtl/loader_pkg.sv
// Shared encodings and defaults for the imem stream loader and its processor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package loader_pkg;

    // Loader FSM encodings; CHK is only reachable in checksum builds.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        HOLD = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4,
        CHK  = 3'd5
    } loader_state_t;

    localparam int DEFAULT_DEPTH          = 32;
    localparam int DEFAULT_RELEASE_CYCLES = 4;

    // Instruction word width, shared with the processor's imem.
    localparam int IMEM_DATA_W = 32;

endpackage

// File: rtl/release_timer.sv
// Loadable down-counter with a zero flag; paces cpu_reset release.
// Latency: load takes effect at the next edge; zero is combinational from the count.
// Backpressure: none, counts freely until zero and then holds.
module release_timer #(
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          zero
);

    logic [TW-1:0] cnt;

    assign zero = (cnt == '0);

    // Load wins over decrement; saturate at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (!zero) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/imem_stream_loader.sv
// Boot loader: streams instruction words into imem from addr 0, holds cpu_reset, then releases it.
// Latency: imem write registered 1 cycle after handshake; cpu_reset falls RELEASE_CYCLES after the last write.
// Backpressure: in_ready high only while accepting words (LOAD, and CHK when LOADER_CHECKSUM_EN is defined).
module imem_stream_loader
    import loader_pkg::*;
#(
    parameter int DEPTH          = DEFAULT_DEPTH,
    parameter int ADDR_W         = $clog2(DEFAULT_DEPTH),
    parameter int DATA_W         = IMEM_DATA_W,
    parameter int RELEASE_CYCLES = DEFAULT_RELEASE_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              error
);

    // The timer is loaded with RELEASE_CYCLES-1 so that HOLD lasts exactly
    // RELEASE_CYCLES edges before the DONE transition drops cpu_reset.
    localparam int TW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [TW-1:0]   TMR_INIT = TW'(RELEASE_CYCLES - 1);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    loader_state_t state, state_nxt;
    logic          hs;
    logic          wr_fire;
    logic          tmr_load;
    logic          tmr_zero;
    logic          clr;
    logic          full;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    assign in_ready = (state == LOAD) || (state == CHK);
`else
    assign in_ready = (state == LOAD);
`endif

    assign hs   = in_valid & in_ready;
    assign full = (word_count == FULL_CNT);
    // Any entry into LOAD starts a fresh program at address 0.
    assign clr  = (state_nxt == LOAD) && (state != LOAD);

    release_timer #(.TW(TW)) u_release_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (TMR_INIT),
        .zero     (tmr_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus write and timer-load strobes.
    always_comb begin
        state_nxt = state;
        wr_fire   = 1'b0;
        tmr_load  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                if (hs) begin
                    // Once DEPTH words are in, any further word overruns imem
                    // and would wrap onto address 0, so it is never written.
                    if (full) begin
                        state_nxt = ERR;
                    end else begin
                        wr_fire = 1'b1;
                        if (in_last) begin
`ifdef LOADER_CHECKSUM_EN
                            state_nxt = CHK;
`else
                            state_nxt = HOLD;
                            tmr_load  = 1'b1;
`endif
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (hs) begin
                    if (in_data == sum) begin
                        state_nxt = HOLD;
                        tmr_load  = 1'b1;
                    end else begin
                        state_nxt = ERR;
                    end
                end
            end
`endif
            HOLD: begin
                if (tmr_zero) state_nxt = DONE;
            end
            DONE, ERR: begin
                if (start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write port, counters and status flags, all registered from next-state decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_count <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= wr_fire;
            if (wr_fire) begin
                imem_addr  <= word_count[ADDR_W-1:0];
                imem_wdata <= in_data;
                word_count <= word_count + 1'b1;
            end
            if (clr) begin
                word_count <= '0;
            end
            cpu_reset <= (state_nxt != DONE);
            done      <= (state_nxt == DONE);
            error     <= (state_nxt == ERR);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Wrapping sum of every word actually written in this load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (wr_fire) begin
            sum <= sum + in_data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader: load, stall, overflow, full depth, async reset, reload.
// Latency: checks writes one cycle after each handshake and release RELEASE_CYCLES after the last one.
// Backpressure: drives in_valid patterns including stalls; checksum cases when LOADER_CHECKSUM_EN is defined.
module tb_imem_stream_loader;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int RC     = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_reset;
    logic [ADDR_W:0]   word_count;
    logic              done;
    logic              error;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DATA_W-1:0] tb_sum;

    imem_stream_loader #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RELEASE_CYCLES(RC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .word_count (word_count),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        tb_sum = '0;
    endtask

    // One handshake cycle; outputs are sampled 1ns after the capturing edge.
    task automatic send_word(input logic [DATA_W-1:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        check(tag, {imem_we, imem_addr, imem_wdata}, {1'b1, a, d});
        tb_sum = tb_sum + d;
    endtask

    // Sends the checksum word in checksum builds; nothing otherwise.
    task automatic finish_prog(input string tag);
`ifdef LOADER_CHECKSUM_EN
        send_word(tb_sum, 1'b0);
        check({tag, "_chk_nowrite"}, imem_we, 1'b0);
`else
        check({tag, "_ready_low"}, in_ready, 1'b0);
`endif
    endtask

    task automatic wait_release(input string tag);
        int n;
        n = 0;
        while (cpu_reset === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_release_cycles"}, n, RC);
        check({tag, "_done"}, {done, error}, 2'b10);
    endtask

    initial begin
        int ok;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        tb_sum   = '0;
        #23;
        check("reset_state", {in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, word_count, done, error},
              {1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 6'd0, 1'b0, 1'b0});
        reset = 1'b0;
        tick();
        check("idle_hold", {in_ready, cpu_reset}, 2'b01);

        // Nominal three-word program, in_valid held high.
        pulse_start();
        check("load_ready", in_ready, 1'b1);
        send_word(32'h0000_0093, 1'b0);
        expect_write("nom_w0", 5'd0, 32'h0000_0093);
        send_word(32'h0010_0113, 1'b0);
        expect_write("nom_w1", 5'd1, 32'h0010_0113);
        send_word(32'h0020_8193, 1'b1);
        expect_write("nom_w2", 5'd2, 32'h0020_8193);
        check("nom_count", word_count, 6'd3);
        finish_prog("nom");
        wait_release("nom");

        // Reload from DONE with a stalled stream; start during LOAD must be ignored.
        pulse_start();
        check("reload_cpu_reset", {cpu_reset, done}, 2'b10);
        send_word(32'h1111_1111, 1'b0);
        expect_write("stall_w0", 5'd0, 32'h1111_1111);
        tick();
        check("stall_gap1", imem_we, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("stall_gap2", imem_we, 1'b0);
        send_word(32'h2222_2222, 1'b1);
        expect_write("stall_w1", 5'd1, 32'h2222_2222);
        check("stall_count", word_count, 6'd2);
        finish_prog("stall");
        wait_release("stall");

        // Overflow: 33 words without in_last.
        pulse_start();
        ok = 0;
        for (int i = 0; i < DEPTH; i++) begin
            send_word(32'hC000_0000 + i, 1'b0);
            if (imem_we === 1'b1 && imem_addr == ADDR_W'(i) && imem_wdata == 32'hC000_0000 + i) ok++;
        end
        check("ovf_writes", ok, DEPTH);
        send_word(32'hDEAD_BEEF, 1'b0);
        check("ovf_no_write", imem_we, 1'b0);
        check("ovf_status", {error, done, cpu_reset, in_ready}, 4'b1010);
        check("ovf_count", word_count, 6'd32);
        tick();
        check("ovf_sticky", {error, cpu_reset}, 2'b11);

        // Full-depth legal program, started from ERR.
        pulse_start();
        check("err_exit", {error, in_ready}, 2'b01);
        ok = 0;
        for (int i = 0; i < DEPTH; i++) begin
            send_word(32'hA000_0000 + i, (i == DEPTH - 1));
            if (imem_we === 1'b1 && imem_addr == ADDR_W'(i)) ok++;
            tb_sum = tb_sum + 32'hA000_0000 + i;
        end
        check("full_writes", ok, DEPTH);
        check("full_count", word_count, 6'd32);
        finish_prog("full");
        wait_release("full");

        // Asynchronous reset between edges after two writes.
        pulse_start();
        send_word(32'h5555_0000, 1'b0);
        send_word(32'h5555_0001, 1'b0);
        expect_write("arst_w1", 5'd1, 32'h5555_0001);
        #3;
        reset = 1'b1;
        #1;
        check("arst_outputs", {imem_we, word_count, cpu_reset, in_ready, done, error},
              {1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        #2;
        reset = 1'b0;
        tick();
        check("arst_idle", {in_ready, cpu_reset}, 2'b01);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum then good checksum.
        pulse_start();
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b1);
        send_word(32'd4, 1'b0);
        check("cks_bad_nowrite", imem_we, 1'b0);
        check("cks_bad_err", {error, cpu_reset, word_count}, {1'b1, 1'b1, 6'd2});
        pulse_start();
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b1);
        send_word(32'd3, 1'b0);
        check("cks_good_count", {imem_we, error, word_count}, {1'b0, 1'b0, 6'd2});
        wait_release("cks_good");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
